// File: rtl/i2c_controller_multibyte.sv
// Single-controller I2C master: START, address+R/W, 0..MAX_BYTES data bytes, STOP.
// Supports target clock stretching, NACK abort and busy/done/nack status.
module i2c_controller_multibyte #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned T_LOW     = 250,
  parameter int unsigned T_HIGH    = 250,
  parameter int unsigned T_HD      = 250,
  parameter int unsigned CNT_W     = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [7:0]                         addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0]     num_bytes,
  input  logic [8*MAX_BYTES-1:0]             data_snt,
  output logic [8*MAX_BYTES-1:0]             data_rcv,
  output logic                               scl,
  input  logic                               scl_in,
  input  logic                               sda_in,
  output logic                               sda_out,
  output logic                               busy,
  output logic                               done,
  output logic                               nack
);

  localparam int unsigned NB_W = $clog2(MAX_BYTES + 1);
  localparam int unsigned K_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int unsigned D_W  = 8 * MAX_BYTES;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
  } state_t;

  // Phase inside a bit slot; PH_HOLD is only used by the final STOP setup time.
  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_HOLD} phase_t;

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [NB_W-1:0]    nb_q, nb_d;
  logic [7:0]         addr_q, addr_d;
  logic [D_W-1:0]     data_q, data_d;
  logic [D_W-1:0]     data_rcv_q, data_rcv_d;
  logic               scl_q, scl_d;
  logic               sda_q, sda_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               nack_q, nack_d;

  logic               low_end, high_end, hd_end, last_byte;
  logic [CNT_W-1:0]   cnt_inc;

  assign low_end   = (cnt_q == CNT_W'(T_LOW - 1));
  assign high_end  = (cnt_q == CNT_W'(T_HIGH - 1));
  assign hd_end    = (cnt_q == CNT_W'(T_HD - 1));
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_byte = ((NB_W'(k_q) + NB_W'(1)) == nb_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_LOW;
      cnt_q      <= '0;
      bit_q      <= '0;
      k_q        <= '0;
      nb_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      data_rcv_q <= '0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      k_q        <= k_d;
      nb_q       <= nb_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      data_rcv_q <= data_rcv_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    k_d        = k_q;
    nb_d       = nb_q;
    addr_d     = addr_q;
    data_d     = data_q;
    data_rcv_d = data_rcv_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    scl_d      = 1'b1;
    sda_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_START;
          cnt_d      = '0;
          addr_d     = addr;
          data_d     = data_snt;
          nb_d       = (num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes;
          data_rcv_d = '0;
          nack_d     = 1'b0;
        end
      end
      S_START: begin
        if (hd_end) begin
          state_d = S_ADDR;
          phase_d = PH_LOW;
          cnt_d   = '0;
          bit_d   = '0;
          k_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STOP: begin
        case (phase_q)
          PH_LOW: begin
            if (low_end) begin
              phase_d = PH_HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          PH_HIGH: begin
            if (scl_in) begin
              if (high_end) begin
                phase_d = PH_HOLD;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
          default: begin
            if (hd_end) begin
              state_d = S_IDLE;
              phase_d = PH_LOW;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end
      default: begin
        // Bit slot: the high phase only advances while the line is really high.
        if (phase_q == PH_LOW) begin
          if (low_end) begin
            phase_d = PH_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (scl_in) begin
          if (!high_end) begin
            cnt_d = cnt_inc;
          end else begin
            phase_d = PH_LOW;
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            case (state_q)
              S_ADDR: begin
                if (bit_q == 3'd7) state_d = S_ADDR_ACK;
              end
              S_ADDR_ACK: begin
                bit_d = '0;
                if (sda_in) begin
                  nack_d  = 1'b1;
                  state_d = S_STOP;
                end else if (nb_q == '0) begin
                  state_d = S_STOP;
                end else begin
                  state_d = addr_q[0] ? S_READ : S_WRITE;
                end
              end
              S_WRITE: begin
                if (bit_q == 3'd7) state_d = S_WRITE_ACK;
              end
              S_WRITE_ACK: begin
                bit_d = '0;
                if (sda_in) begin
                  nack_d  = 1'b1;
                  state_d = S_STOP;
                end else if (last_byte) begin
                  state_d = S_STOP;
                end else begin
                  k_d     = k_q + K_W'(1);
                  state_d = S_WRITE;
                end
              end
              S_READ: begin
                data_rcv_d[{k_q, ~bit_q}] = sda_in;
                if (bit_q == 3'd7) state_d = S_READ_ACK;
              end
              S_READ_ACK: begin
                bit_d = '0;
                if (last_byte) begin
                  state_d = S_STOP;
                end else begin
                  k_d     = k_q + K_W'(1);
                  state_d = S_READ;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    // Line drive decoded from the position the FSM moves into, so pins change with the state.
    case (state_d)
      S_IDLE:  ;
      S_START: sda_d = 1'b0;
      S_STOP: begin
        scl_d = (phase_d != PH_LOW);
        sda_d = (phase_d == PH_HOLD);
      end
      default: begin
        scl_d = (phase_d != PH_LOW);
        case (state_d)
          S_ADDR:     sda_d = addr_q[~bit_d];
          S_WRITE:    sda_d = data_q[{k_d, ~bit_d}];
          S_READ_ACK: sda_d = ((NB_W'(k_d) + NB_W'(1)) == nb_q);
          default:    sda_d = 1'b1;
        endcase
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign data_rcv = data_rcv_q;
  assign scl      = scl_q;
  assign sda_out  = sda_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;

endmodule

// File: tb/tb_i2c_controller_multibyte.sv
// Bench for i2c_controller_multibyte: an I2C target model drives the bus, and a
// reference model built from the protocol rules predicts wire bits, read data, status and latency.
module tb_i2c_controller_multibyte;

  localparam int unsigned MAXB = 4;
  localparam int unsigned TL   = 4;
  localparam int unsigned TH   = 4;
  localparam int unsigned THD  = 4;
  localparam int unsigned NBW  = $clog2(MAXB + 1);
  localparam int unsigned DW   = 8 * MAXB;
  localparam int unsigned SLOT = TL + TH;

  logic            clk       = 1'b0;
  logic            rst       = 1'b0;
  logic            start     = 1'b0;
  logic [7:0]      addr      = '0;
  logic [NBW-1:0]  num_bytes = '0;
  logic [DW-1:0]   data_snt  = '0;
  logic [DW-1:0]   data_rcv;
  logic            scl, scl_in, sda_in, sda_out, busy, done, nack;
  logic            sda_tgt   = 1'b1;
  logic            scl_hold  = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Open-drain bus: the line is low if either side pulls it low.
  assign sda_in = sda_out & sda_tgt;
  assign scl_in = scl & ~scl_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_controller_multibyte #(
    .MAX_BYTES(MAXB), .T_LOW(TL), .T_HIGH(TH), .T_HD(THD), .CNT_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .num_bytes(num_bytes),
    .data_snt(data_snt), .data_rcv(data_rcv), .scl(scl), .scl_in(scl_in),
    .sda_in(sda_in), .sda_out(sda_out), .busy(busy), .done(done), .nack(nack)
  );

  logic          tgt  [64];
  logic          expb [64];
  logic          capb [64];
  int            exp_len;
  logic [DW-1:0] exp_rcv;
  logic          exp_nack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected wire bit per slot and what the target drives in each slot.
  task automatic model(input logic [7:0] a, input int nreq, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rd, input bit aack, input int wnack_at);
    int nb;
    int s;
    nb = (nreq > int'(MAXB)) ? int'(MAXB) : nreq;
    for (int i = 0; i < 64; i++) begin
      tgt[i]  = 1'b1;
      expb[i] = 1'b0;
    end
    s        = 0;
    exp_rcv  = '0;
    exp_nack = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      expb[s] = a[i];
      s++;
    end
    tgt[s]  = aack ? 1'b0 : 1'b1;
    expb[s] = tgt[s];
    s++;
    if (!aack) begin
      exp_nack = 1'b1;
    end else begin
      for (int k = 0; k < nb; k++) begin
        if (!a[0]) begin
          for (int i = 7; i >= 0; i--) begin
            expb[s] = wd[8*k+i];
            s++;
          end
          tgt[s]  = (k == wnack_at) ? 1'b1 : 1'b0;
          expb[s] = tgt[s];
          s++;
          if (k == wnack_at) begin
            exp_nack = 1'b1;
            break;
          end
        end else begin
          for (int i = 7; i >= 0; i--) begin
            tgt[s]  = rd[8*k+i];
            expb[s] = rd[8*k+i];
            s++;
          end
          expb[s] = (k == nb - 1) ? 1'b1 : 1'b0;
          s++;
          exp_rcv[8*k +: 8] = rd[8*k +: 8];
        end
      end
    end
    exp_len = s;
  endtask

  task automatic run(input string tag, input logic [7:0] a, input int nreq,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd, input bit aack,
                     input int wnack_at, input int stretch, input int abort_slot, input bit spam);
    int          n0, slot, cap_n, scnt, lat, exp_lat;
    bit          got, prev_scl, prev_line, stretched;
    logic [63:0] ov, ev;
    model(a, nreq, wd, rd, aack, wnack_at);
    @(negedge clk);
    addr      = a;
    num_bytes = NBW'(nreq);
    data_snt  = wd;
    start     = 1'b1;
    n0        = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_rise"}, 64'(busy), 64'd1);
    check({tag, " start_cond"}, 64'({scl, sda_out}), 64'b10);
    slot = -1; cap_n = 0; scnt = 0; lat = -1;
    got = 1'b0; stretched = 1'b0;
    sda_tgt   = 1'b1;
    scl_hold  = 1'b0;
    prev_scl  = scl;
    prev_line = sda_out & sda_tgt;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      start = (spam && t < 200 && (t % 23) == 3) ? 1'b1 : 1'b0;
      if (prev_scl && !scl) begin
        if (slot >= 0 && slot < 64) begin
          capb[slot] = prev_line;
          cap_n++;
        end
        slot++;
        sda_tgt = (slot < 64) ? tgt[slot] : 1'b1;
      end
      if (!prev_scl && scl && slot == 0 && stretch > 0 && !stretched) begin
        scnt      = stretch;
        stretched = 1'b1;
      end else if (scnt > 0) begin
        scnt--;
      end
      scl_hold  = (scnt > 0);
      prev_scl  = scl;
      prev_line = sda_out & sda_tgt;
      if (abort_slot >= 0 && slot == abort_slot) begin
        rst = 1'b0;
        #1;
        check({tag, " rst_lines"}, 64'({scl, sda_out, busy, done, nack}), 64'b11000);
        check({tag, " rst_rcv"}, 64'(data_rcv), 64'd0);
        @(negedge clk);
        rst      = 1'b1;
        sda_tgt  = 1'b1;
        scl_hold = 1'b0;
        return;
      end
      if (done) begin
        got = 1'b1;
        lat = cyc - n0;
      end
    end
    start   = 1'b0;
    exp_lat = 1 + int'(THD) + exp_len * int'(SLOT) + int'(SLOT) + int'(THD) + stretch;
    ov = '0;
    ev = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < cap_n)   ov[i] = capb[i];
      if (i < exp_len) ev[i] = expb[i];
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " nack"}, 64'(nack), 64'(exp_nack));
    check({tag, " data_rcv"}, 64'(data_rcv), 64'(exp_rcv));
    check({tag, " slot_count"}, 64'(cap_n), 64'(exp_len));
    check({tag, " wire_bits"}, ov, ev);
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " idle_lines"}, 64'({scl, sda_out}), 64'b11);
    check({tag, " nack_sticky"}, 64'(nack), 64'(exp_nack));
  endtask

  initial begin
    logic [7:0]    ra;
    logic [DW-1:0] rw, rr;
    int            rn, rk;
    bit            rack;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset lines", 64'({scl, sda_out, busy, done, nack}), 64'b11000);
    check("reset rcv", 64'(data_rcv), 64'd0);
    rst = 1'b1;

    run("write",     8'hA0, 2, 32'h0000_5AC3, '0,           1'b1, -1, 0,  -1, 1'b0);
    run("read",      8'hA1, 3, DW'($urandom), 32'h0033_2211, 1'b1, -1, 0,  -1, 1'b0);
    run("addr_nack", 8'h42, 2, DW'($urandom), '0,           1'b0, -1, 0,  -1, 1'b0);
    run("stretch",   8'hA0, 2, 32'h0000_5AC3, '0,           1'b1, -1, 20, -1, 1'b0);
    run("probe",     8'h50, 0, DW'($urandom), '0,           1'b1, -1, 0,  -1, 1'b0);
    run("clamp_wr",  8'h3C, 7, DW'($urandom), '0,           1'b1, -1, 0,  -1, 1'b0);
    run("clamp_rd",  8'h3D, 7, '0,           DW'($urandom), 1'b1, -1, 0,  -1, 1'b0);
    run("wr_nack",   8'hA0, 4, DW'($urandom), '0,           1'b1, 1,  0,  -1, 1'b0);
    run("rst_mid",   8'hA0, 4, DW'($urandom), '0,           1'b1, -1, 0,  20, 1'b0);
    run("after_rst", 8'hA0, 2, DW'($urandom), '0,           1'b1, -1, 0,  -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ra   = 8'($urandom);
      rw   = DW'($urandom);
      rr   = DW'($urandom);
      rn   = int'($urandom_range(0, 7));
      rk   = int'($urandom_range(0, 5));
      rack = ($urandom_range(0, 5) != 0);
      run($sformatf("rnd%0d", i), ra, rn, rw, rr, rack, rk, 0, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
